// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: byte-stream input, held-frame output and payload
// read port of uart_rx_frame_ctrl. clk and reset_n stay outside as plain ports.
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          frame_valid;
  logic [7:0]    frame_cmd;
  logic [7:0]    frame_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_ack;
  logic          busy;
  logic          err_chk;
  logic          err_len;
  logic          err_timeout;
  logic          err_ovr;

  // Receiver / consumer side
  modport master (
    output rx_dv, rx_byte, rd_addr, frame_ack,
    input  frame_valid, frame_cmd, frame_len, rd_data, busy,
           err_chk, err_len, err_timeout, err_ovr
  );

  // Frame controller side
  modport slave (
    input  rx_dv, rx_byte, rd_addr, frame_ack,
    output frame_valid, frame_cmd, frame_len, rd_data, busy,
           err_chk, err_len, err_timeout, err_ovr
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SYNC, CMD, LEN, payload, CHK from the uart_rx
// byte stream, checks length/checksum/inter-byte timing, buffers the payload
// and holds the decoded frame until the consumer acknowledges it.
// Build option: define UART_FRAME_CRC8_EN to use CRC-8 (poly 0x07, init 0,
// MSB-first) as CHK instead of the plain XOR of CMD, LEN and payload.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input logic                 clk,
  input logic                 reset_n,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    fcmd_q, fcmd_d;
  logic [7:0]    flen_q, flen_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_ovr_q, err_ovr_d;
  logic          tmo_exp;
  logic          buf_we;
  logic [7:0]    buf_q [MAX_LEN];

  // One byte of check accumulation: CRC-8 or XOR depending on build.
  function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
`ifdef UART_FRAME_CRC8_EN
    r = c ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
`else
    r = c ^ b;
`endif
    return r;
  endfunction

  // State and frame registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      fcmd_q    <= '0;
      flen_q    <= '0;
      tmo_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      fcmd_q    <= fcmd_d;
      flen_q    <= flen_d;
      tmo_q     <= tmo_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  // Payload buffer: written only while parsing payload, so frozen during HOLD
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[AW-1:0]] <= bus.rx_byte;
    end
  end

  // Next-state, checksum, inter-byte timeout and error pulse generation
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    fcmd_d    = fcmd_q;
    flen_d    = flen_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;
    buf_we    = 1'b0;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    tmo_exp = (tmo_q == TMO_LAST) && !bus.rx_dv;
    if ((state_q == S_IDLE) || (state_q == S_HOLD) || bus.rx_dv || tmo_exp) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_dv && (bus.rx_byte == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.rx_dv) begin
          cmd_d   = bus.rx_byte;
          chk_d   = chk_step('0, bus.rx_byte);
          state_d = S_LEN;
        end else if (tmo_exp) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_LEN: begin
        if (bus.rx_dv) begin
          chk_d = chk_step(chk_q, bus.rx_byte);
          if (bus.rx_byte > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = bus.rx_byte;
            idx_d   = '0;
            state_d = (bus.rx_byte == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end else if (tmo_exp) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_dv) begin
          buf_we = 1'b1;
          chk_d  = chk_step(chk_q, bus.rx_byte);
          idx_d  = idx_q + 8'd1;
          if (idx_q == (len_q - 8'd1)) begin
            state_d = S_CHK;
          end
        end else if (tmo_exp) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CHK: begin
        if (bus.rx_dv) begin
          if (bus.rx_byte == chk_q) begin
            fcmd_d  = cmd_q;
            flen_d  = len_q;
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (tmo_exp) begin
          err_tmo_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_HOLD: begin
        // A byte arriving here is dropped even when ack arrives with it.
        if (bus.rx_dv) begin
          err_ovr_d = 1'b1;
        end
        if (bus.frame_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.frame_valid = (state_q == S_HOLD);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.frame_cmd   = fcmd_q;
  assign bus.frame_len   = flen_q;
  assign bus.rd_data     = buf_q[bus.rd_addr];
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_tmo_q;
  assign bus.err_ovr     = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames against a queue-based frame model,
// compared every cycle, plus hand-computed literal expectations.
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned MLEN = 16;
  localparam int unsigned TMO  = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  uart_rx_frame_ctrl_if #(.MAX_LEN(MLEN)) bus ();

  uart_rx_frame_ctrl #(
    .SYNC_BYTE   (SYNC),
    .MAX_LEN     (MLEN),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check accumulation written as bit-serial polynomial division for CRC-8
  function automatic logic [7:0] mstep(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c;
`ifdef UART_FRAME_CRC8_EN
    for (int i = 7; i >= 0; i--) begin
      logic fb;
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
`else
    r = r ^ b;
`endif
    return r;
  endfunction

  // ---------------- frame model ----------------
  bit          in_frame = 0;
  bit          held = 0;
  logic [7:0]  cur[$];
  int          gap = 0;
  logic [7:0]  m_cmd = '0;
  logic [7:0]  m_len = '0;
  logic [7:0]  m_pay[$];
  bit          e_chk = 0, e_len = 0, e_tmo = 0, e_ovr = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame = 0; held = 0; cur.delete(); gap = 0;
      m_cmd = '0; m_len = '0;
      e_chk = 0; e_len = 0; e_tmo = 0; e_ovr = 0;
    end else begin
      e_chk = 0; e_len = 0; e_tmo = 0; e_ovr = 0;
      if (held) begin
        if (bus.rx_dv) e_ovr = 1;
        if (bus.frame_ack) held = 0;
      end else if (!in_frame) begin
        if (bus.rx_dv && bus.rx_byte == SYNC) begin
          in_frame = 1; cur.delete(); gap = 0;
        end
      end else if (bus.rx_dv) begin
        gap = 0;
        cur.push_back(bus.rx_byte);
        if (cur.size() == 2 && cur[1] > 8'(MLEN)) begin
          e_len = 1; in_frame = 0;
        end else if (cur.size() >= 3 && cur.size() == int'(cur[1]) + 3) begin
          logic [7:0] acc;
          acc = '0;
          for (int i = 0; i < cur.size() - 1; i++) acc = mstep(acc, cur[i]);
          if (acc == cur[cur.size()-1]) begin
            held = 1; m_cmd = cur[0]; m_len = cur[1];
            m_pay.delete();
            for (int i = 0; i < int'(cur[1]); i++) m_pay.push_back(cur[2+i]);
          end else begin
            e_chk = 1;
          end
          in_frame = 0;
        end
      end else begin
        gap++;
        if (gap == TMO) begin
          e_tmo = 1; in_frame = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare and pulse counters ----------------
  int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

  always @(negedge clk) begin
    chk("frame_valid", bus.frame_valid, held);
    chk("busy", bus.busy, in_frame || held);
    chk("err_chk", bus.err_chk, e_chk);
    chk("err_len", bus.err_len, e_len);
    chk("err_timeout", bus.err_timeout, e_tmo);
    chk("err_ovr", bus.err_ovr, e_ovr);
    if (held) begin
      chk("frame_cmd", bus.frame_cmd, m_cmd);
      chk("frame_len", bus.frame_len, m_len);
      if (bus.rd_addr < m_len) chk("rd_data", bus.rd_data, m_pay[bus.rd_addr]);
    end
    if (bus.err_chk) n_chk++;
    if (bus.err_len) n_len++;
    if (bus.err_timeout) n_tmo++;
    if (bus.err_ovr) n_ovr++;
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    bus.rx_dv = 1'b1;
    bus.rx_byte = b;
    @(posedge clk); #1;
    bus.rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] pay[$], input bit good);
    logic [7:0] acc;
    acc = mstep(8'h00, cmd);
    acc = mstep(acc, 8'(pay.size()));
    foreach (pay[i]) acc = mstep(acc, pay[i]);
    send_byte(SYNC);
    send_byte(cmd);
    send_byte(8'(pay.size()));
    foreach (pay[i]) send_byte(pay[i]);
    send_byte(good ? acc : ~acc);
  endtask

  initial begin
    logic [7:0] p[$];
    int base;
    bus.rx_dv = 1'b0; bus.rx_byte = '0; bus.frame_ack = 1'b0; bus.rd_addr = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst frame_valid", bus.frame_valid, 1'b0);
    chk("rst frame_cmd", bus.frame_cmd, 8'h00);
    chk("rst frame_len", bus.frame_len, 8'h00);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst errs", {bus.err_chk, bus.err_len, bus.err_timeout, bus.err_ovr}, 4'b0000);
    reset_n = 1'b1;
    idle(2);

`ifndef UART_FRAME_CRC8_EN
    chk("model xor pin", mstep(mstep(mstep(mstep(mstep(8'h00, 8'h10), 8'h03), 8'h11), 8'h22), 8'h33), 8'h13);
`endif

    // Good frame with hand bytes; XOR of 10 03 11 22 33 is 13
    p = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, p, 1'b1);
    chk("good frame_valid", bus.frame_valid, 1'b1);
    chk("good frame_cmd", bus.frame_cmd, 8'h10);
    chk("good frame_len", bus.frame_len, 8'h03);
    bus.rd_addr = 4'd0; #1 chk("rd0", bus.rd_data, 8'h11);
    bus.rd_addr = 4'd1; #1 chk("rd1", bus.rd_data, 8'h22);
    bus.rd_addr = 4'd2; #1 chk("rd2", bus.rd_data, 8'h33);
    bus.rd_addr = 4'd0;
    idle(2);
    ack();
    chk("ack frame_valid", bus.frame_valid, 1'b0);
    chk("ack busy", bus.busy, 1'b0);

    // Zero-length frame A5 7E 00 7E
    send_byte(SYNC); send_byte(8'h7E); send_byte(8'h00);
`ifndef UART_FRAME_CRC8_EN
    send_byte(8'h7E);
    chk("zero frame_valid", bus.frame_valid, 1'b1);
    chk("zero frame_len", bus.frame_len, 8'h00);
`else
    send_byte(mstep(mstep(8'h00, 8'h7E), 8'h00));
`endif
    ack();

    // Bad checksum: explicit 00 and the wrong-by-construction inverted check
    base = n_chk;
    send_byte(SYNC); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h00);
    idle(1);
    chk("badchk pulses", n_chk - base, 1);
    chk("badchk frame_valid", bus.frame_valid, 1'b0);
    chk("badchk busy", bus.busy, 1'b0);
    send_byte(SYNC); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'hC3);
    idle(1);
`ifndef UART_FRAME_CRC8_EN
    chk("c3 chk pulses", n_chk - base, 2);
`endif
    p = '{8'h01, 8'h02};
    send_frame(8'h33, p, 1'b0);
    idle(1);

    // Length error A5 01 11 (17 > 16), then recovery frame with SYNC as data
    base = n_len;
    send_byte(SYNC); send_byte(8'h01); send_byte(8'h11);
    idle(1);
    chk("len pulses", n_len - base, 1);
    chk("len busy", bus.busy, 1'b0);
    p = '{8'hA5, 8'h01};
    send_frame(8'hA5, p, 1'b1);
    chk("syncdata frame_cmd", bus.frame_cmd, 8'hA5);
    ack();

    // Maximum length 16 frame, overrun while held, ack together with a byte
    p.delete();
    for (int i = 0; i < 16; i++) p.push_back(8'(i * 7 + 1));
    send_frame(8'h42, p, 1'b1);
    chk("max frame_len", bus.frame_len, 8'd16);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 4'(i);
      idle(1);
    end
    bus.rd_addr = 4'd15; #1 chk("rd15", bus.rd_data, 8'd106);
    base = n_ovr;
    send_byte(SYNC);
    idle(1);
    chk("ovr pulses", n_ovr - base, 1);
    chk("ovr frame_valid", bus.frame_valid, 1'b1);
    chk("ovr frame_cmd", bus.frame_cmd, 8'h42);
    bus.frame_ack = 1'b1; bus.rx_dv = 1'b1; bus.rx_byte = SYNC;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0; bus.rx_dv = 1'b0;
    idle(1);
    chk("ovr+ack pulses", n_ovr - base, 2);
    chk("ovr+ack busy", bus.busy, 1'b0);
    bus.rd_addr = 4'd0;

    // Ack outside HOLD has no effect
    ack();
    chk("stray ack busy", bus.busy, 1'b0);

    // Byte on the expiry cycle accepted; then a full idle window times out
    base = n_tmo;
    send_byte(SYNC); send_byte(8'h10);
    idle(TMO - 1);
    send_byte(8'h03);
    chk("edge no tmo", n_tmo - base, 0);
    chk("edge busy", bus.busy, 1'b1);
    idle(TMO);
    idle(1);
    chk("tmo pulses", n_tmo - base, 1);
    chk("tmo busy", bus.busy, 1'b0);

    // Reset mid-payload
    send_byte(SYNC); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    reset_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst frame_valid", bus.frame_valid, 1'b0);
    chk("midrst errs", {bus.err_chk, bus.err_len, bus.err_timeout, bus.err_ovr}, 4'b0000);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    p = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, p, 1'b1);
    chk("post-rst frame_valid", bus.frame_valid, 1'b1);
    ack();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
